guitar_input_conditioner: RTL and testbench



---
 rtl/guitar_input_pkg.sv | 19 +
 rtl/guitar_input_conditioner_if.sv | 33 +++
 rtl/debounce_channel.sv | 47 ++++
 rtl/guitar_input_conditioner_checker.sv | 25 ++
 rtl/guitar_input_conditioner.sv | 133 +++++++++++++
 tb/tb_guitar_input_conditioner.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/guitar_input_pkg.sv
// Shared types and constants for the guitar input conditioner.
// Also holds the counter-width helper used by every counter in the block.
package guitar_input_pkg;

    localparam int NUM_FRETS   = 4;
    localparam int STRUM_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD         = 2'd1,
        WAIT_RELEASE = 2'd2
    } strum_state_t;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/guitar_input_conditioner_if.sv
// Player-side raw inputs and processor-side conditioned outputs.
// The conditioner sits on the slave side.
interface guitar_input_conditioner_if;
    import guitar_input_pkg::*;

    logic [NUM_FRETS-1:0]   buttons_raw;
    logic                   strum_raw;
    logic                   run;
    logic [NUM_FRETS-1:0]   buttons;
    logic                   strum;
    logic                   gameclk;
    logic [STRUM_CNT_W-1:0] strum_count;

    modport master (
        output buttons_raw,
        output strum_raw,
        output run,
        input  buttons,
        input  strum,
        input  gameclk,
        input  strum_count
    );

    modport slave (
        input  buttons_raw,
        input  strum_raw,
        input  run,
        output buttons,
        output strum,
        output gameclk,
        output strum_count
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounced input: two-flop synchronizer, disagreement counter and stable register.
// The stable value moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce_channel
    import guitar_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then count consecutive disagreements; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= CNT_ZERO;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/guitar_input_conditioner_checker.sv
// Structural invariants of the strum FSM and gameclk divider.
module guitar_input_conditioner_checker
    import guitar_input_pkg::*;
#(
    parameter int DIV_W = 1,
    parameter int GAMECLK_DIV = 4
) (
    input logic             clock,
    input logic             reset,
    input strum_state_t     state,
    input logic             strum,
    input logic [DIV_W-1:0] div_cnt
);

    // strum is the registered image of "next state is HOLD", so it tracks HOLD exactly.
    strum_matches_hold: assert property (@(posedge clock) disable iff (!reset)
        strum == (state == HOLD));

    state_legal: assert property (@(posedge clock) disable iff (!reset)
        state != strum_state_t'(2'd3));

    div_in_range: assert property (@(posedge clock) disable iff (!reset)
        int'(div_cnt) < GAMECLK_DIV);

endmodule

// File: rtl/guitar_input_conditioner.sv
// Fret/strum debouncing, one-shot strum pulse generation and pausable gameclk divider
// feeding the Guitar Hero processor inputs.
module guitar_input_conditioner
    import guitar_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STRUM_HOLD      = 8,
    parameter int GAMECLK_DIV     = 4
) (
    input logic                       clock,
    input logic                       reset,
    guitar_input_conditioner_if.slave bus
);

    localparam int                HOLD_W    = cnt_width(STRUM_HOLD);
    localparam int                DIV_W     = cnt_width(GAMECLK_DIV);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(STRUM_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(GAMECLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [STRUM_CNT_W-1:0] CNT_ZERO = {STRUM_CNT_W{1'b0}};
    localparam logic [STRUM_CNT_W-1:0] CNT_ONE  = STRUM_CNT_W'(1);

    logic [NUM_FRETS-1:0]   fret_db_s;
    logic                   strum_db_s;
    strum_state_t           state_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic                   strum_r;
    logic [STRUM_CNT_W-1:0] strum_count_r;
    logic [DIV_W-1:0]       div_cnt_r;
    logic                   gameclk_r;

    for (genvar g = 0; g < NUM_FRETS; g++) begin : g_fret
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_fret (
            .clock  (clock),
            .reset  (reset),
            .din    (bus.buttons_raw[g]),
            .stable (fret_db_s[g])
        );
    end

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_strum (
        .clock  (clock),
        .reset  (reset),
        .din    (bus.strum_raw),
        .stable (strum_db_s)
    );

    // Strum FSM: strum_r is loaded with (next state == HOLD) so the pulse aligns with HOLD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            hold_cnt_r    <= HOLD_ZERO;
            strum_r       <= 1'b0;
            strum_count_r <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (strum_db_s) begin
                        state_r       <= HOLD;
                        hold_cnt_r    <= HOLD_LOAD;
                        strum_r       <= 1'b1;
                        strum_count_r <= strum_count_r + CNT_ONE;
                    end else begin
                        strum_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_r == HOLD_ZERO) begin
                        state_r <= strum_db_s ? WAIT_RELEASE : IDLE;
                        strum_r <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                        strum_r    <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    strum_r <= 1'b0;
                    if (!strum_db_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_RELEASE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    strum_r <= 1'b0;
                end
            endcase
        end
    end

    // gameclk divider: counts only while run is high, so pausing preserves the phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= DIV_ZERO;
            gameclk_r <= 1'b0;
        end else if (bus.run) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= DIV_ZERO;
                gameclk_r <= ~gameclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
        end else begin
            div_cnt_r <= div_cnt_r;
            gameclk_r <= gameclk_r;
        end
    end

    guitar_input_conditioner_checker #(
        .DIV_W       (DIV_W),
        .GAMECLK_DIV (GAMECLK_DIV)
    ) u_chk (
        .clock   (clock),
        .reset   (reset),
        .state   (state_r),
        .strum   (strum_r),
        .div_cnt (div_cnt_r)
    );

    assign bus.buttons     = fret_db_s;
    assign bus.strum       = strum_r;
    assign bus.gameclk     = gameclk_r;
    assign bus.strum_count = strum_count_r;

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Self-checking bench: per-cycle expectations queued when stimulus is driven and
// compared one clock later, plus direct checks around the asynchronous reset.
module tb_guitar_input_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam int DIV  = 2;

    typedef struct {
        logic [3:0] braw;
        logic       sraw;
        logic       run;
        logic [3:0] ebtn;
        logic       estrum;
        logic       egc;
        logic [7:0] ecnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    guitar_input_conditioner_if ifc ();

    guitar_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STRUM_HOLD      (HOLD),
        .GAMECLK_DIV     (DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    vec_t exp_q[$];
    vec_t fret_tab[26];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ph       = 0;

    function automatic vec_t mk(input logic [3:0] braw, input logic sraw, input logic run,
                                input logic [3:0] ebtn, input logic estrum, input logic egc,
                                input logic [7:0] ecnt);
        vec_t v;
        v.braw = braw; v.sraw = sraw; v.run = run;
        v.ebtn = ebtn; v.estrum = estrum; v.egc = egc; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive, queue the expectation, let one active edge pass, compare.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        ifc.buttons_raw = v.braw;
        ifc.strum_raw   = v.sraw;
        ifc.run         = v.run;
        exp_q.push_back(v);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check({tag, "_buttons"}, {4'b0000, ifc.buttons}, {4'b0000, e.ebtn});
        check({tag, "_strum"},   {7'b0000000, ifc.strum},   {7'b0000000, e.estrum});
        check({tag, "_gameclk"}, {7'b0000000, ifc.gameclk}, {7'b0000000, e.egc});
        check({tag, "_count"},   ifc.strum_count, e.ecnt);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_buttons"}, {4'b0000, ifc.buttons}, 8'h00);
        check({tag, "_strum"},   {7'b0000000, ifc.strum},   8'h00);
        check({tag, "_gameclk"}, {7'b0000000, ifc.gameclk}, 8'h00);
        check({tag, "_count"},   ifc.strum_count, 8'h00);
    endtask

    initial begin
        // Fret table: 0101 press, 3-cycle 1000 glitch, then release to 0000.
        for (int i = 0; i < 8; i++)
            fret_tab[i] = mk(4'b0101, 1'b0, 1'b0, (i < 5) ? 4'b0000 : 4'b0101, 1'b0, 1'b0, 8'd0);
        for (int i = 8; i < 11; i++)
            fret_tab[i] = mk(4'b1101, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 8'd0);
        for (int i = 11; i < 19; i++)
            fret_tab[i] = mk(4'b0101, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0, 8'd0);
        for (int i = 19; i < 26; i++)
            fret_tab[i] = mk(4'b0000, 1'b0, 1'b0, (i < 24) ? 4'b0101 : 4'b0000, 1'b0, 1'b0, 8'd0);

        ifc.buttons_raw = 4'b0000;
        ifc.strum_raw   = 1'b0;
        ifc.run         = 1'b0;
        reset           = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_zero("reset_state");
        reset = 1'b1;

        for (int i = 0; i < 26; i++)
            apply(fret_tab[i], "fret");

        // Strum held 20 cycles: one 3-cycle pulse starting 6 edges after the first sample.
        for (int i = 0; i < 20; i++)
            apply(mk(4'b0000, 1'b1, 1'b0, 4'b0000, (i >= 6 && i <= 8), 1'b0,
                     (i >= 6) ? 8'd1 : 8'd0), "strum_hold");
        for (int i = 0; i < 10; i++)
            apply(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1), "strum_release");

        reset = 1'b0;
        @(negedge clock);
        check_zero("reset_between");
        reset = 1'b1;

        // 256 clean strums: count wraps back to zero.
        for (int k = 1; k <= 256; k++)
            for (int i = 0; i < 20; i++)
                apply(mk(4'b0000, (i < 10), 1'b0, 4'b0000, (i >= 6 && i <= 8), 1'b0,
                         (i >= 6) ? 8'(k) : 8'(k - 1)), "wrap");
        check("wrap_final_count", ifc.strum_count, 8'h00);

        // Bouncing strum (2 high / 2 low) then held: only one pulse.
        for (int i = 0; i < 40; i++)
            apply(mk(4'b0000, (i < 20) ? (((i / 2) % 2) == 0) : 1'b1, 1'b0, 4'b0000,
                     (i >= 26 && i <= 28), 1'b0, (i >= 26) ? 8'd1 : 8'd0), "bounce");
        for (int i = 0; i < 10; i++)
            apply(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1), "bounce_release");

        // gameclk: toggles every DIV enabled edges; a 7-cycle pause keeps the phase.
        for (int i = 0; i < 27; i++) begin
            logic r;
            r = !(i >= 9 && i < 16);
            if (r) ph++;
            apply(mk(4'b0000, 1'b0, r, 4'b0000, 1'b0, 1'((ph / DIV) % 2), 8'd1), "gameclk");
        end

        // Into HOLD with frets pressed and gameclk running, then reset asynchronously.
        for (int i = 0; i < 7; i++) begin
            ph++;
            apply(mk(4'b0011, 1'b1, 1'b1, (i >= 5) ? 4'b0011 : 4'b0000, (i >= 6),
                     1'((ph / DIV) % 2), (i >= 6) ? 8'd2 : 8'd1), "pre_reset");
        end
        check("pre_reset_gameclk_high", {7'b0000000, ifc.gameclk}, 8'h01);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++)
            apply(mk(4'b0011, 1'b1, 1'b0, (i >= 5) ? 4'b0011 : 4'b0000, (i >= 6 && i <= 8),
                     1'b0, (i >= 6) ? 8'd1 : 8'd0), "post_reset");

        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
